// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
//   arb_state_t  - arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   BURST_CNT_W  - width of the per-grant beat counter
//   *_DEF        - default NUM_REQ / DATA_WIDTH / MAX_BURST shared with the tile top
//   id_w()       - index width for a requester count (never zero)
package fifo_arb_pkg;
  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;
  localparam int BURST_CNT_W    = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer handshake + FIFO write side of the arbiter.
//   req_valid/req_data/req_ready - per-producer valid/ready, data packed per requester
//   fifo_full/fifo_almost_full   - FIFO status flags
//   fifo_wr_en/fifo_wr_data      - registered FIFO write port
//   grant_valid/grant_id         - current (or last) owner of the write port
// Modports: master = producers/FIFO/testbench side, slave = arbiter.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          grant_valid;
  logic [ID_W-1:0]               grant_id;

  modport master (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
//   req    - request vector
//   ptr    - last-granted index; search starts at ptr+1 and wraps
//   any    - at least one request present
//   winner - first requesting index found (0 when none)
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] winner
);
  logic found;
  int   idx;

  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers. The owner keeps the port for up to MAX_BURST
// beats; writes stall on fifo_full and are paced to every other cycle while
// fifo_almost_full is set, so the full flag is never stale when sampled.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - fifo_write_arbiter_if.slave (producer + FIFO write side)
// Optional: define FIFO_ARB_PRIORITY_EN to make requester 0 win every
// arbitration it takes part in; its releases leave the round-robin pointer alone.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo_write_arbiter_if.slave  bus
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam logic [ID_W-1:0]        PTR_RST    = ID_W'(NUM_REQ - 1);
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST);

  arb_state_t             state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic                   pick_any;
  logic [ID_W-1:0]        pick_id, win_id;
  logic                   ok, beat, owner_valid;
  logic [NUM_REQ-1:0]     ready;
  logic [BURST_CNT_W-1:0] cnt_inc;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_id)
  );

`ifdef FIFO_ARB_PRIORITY_EN
  assign win_id = bus.req_valid[0] ? '0 : pick_id;
`else
  assign win_id = pick_id;
`endif

  // After a write while almost full, skip one cycle so the FIFO's full flag
  // has caught up before the next accept.
  assign ok          = !bus.fifo_full && (!bus.fifo_almost_full || !wr_en_q);
  assign owner_valid = bus.req_valid[gid_q];
  assign beat        = (state_q == ARB_GRANT) && ok && owner_valid;
  assign cnt_inc     = cnt_q + BURST_CNT_W'(1);

  // Ready depends on state and flags only, never on req_valid.
  always_comb begin
    ready = '0;
    if (state_q == ARB_GRANT && ok) ready[gid_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          gid_d   = win_id;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
          cnt_d     = cnt_inc;
        end
        // A full-FIFO stall with valid held is not a release.
        if (!owner_valid || (beat && cnt_inc == BURST_LAST)) begin
          state_d = ARB_IDLE;
`ifdef FIFO_ARB_PRIORITY_EN
          if (gid_q != '0) ptr_d = gid_q;
`else
          ptr_d = gid_q;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= PTR_RST;
      gid_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.grant_valid  = (state_q == ARB_GRANT);
  assign bus.grant_id     = gid_q;
endmodule
